uart_tx_frame_engine: RTL and testbench
=======================================

Name: uart_tx_frame_engine

Overview:
- Parametrised successor to the 16750 UART transmitter core.
- Serialises words from a ready/valid input into asynchronous frames:
  - 5..DW data bits, LSB first;
  - five parity modes;
  - 1, 1.5 or 2 stop bits.
- Bit timing comes from an internal oversample counter driven by a TXCLK enable.
- Has a one-word holding register, so frames go back-to-back with no idle gap.
- Sits between the TX FIFO and the SOUT pad logic of the UART top.

Parameters:
- DW, 8, maximum data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, TXCLK pulses per bit time; must be even and >= 2.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- TXCLK  in  1  one-CLK-wide enable pulse at OVERSAMPLE x baud rate
- CLEAR  in  1  synchronous abort and flush
- WLEN  in  4  data bits per frame, 5..DW; any other value is treated as DW
- PMODE  in  3  000 none, 001 odd, 010 even, 011 mark (1), 100 space (0); others treated as none
- STOPB  in  2  00 one stop bit, 01 1.5 stop bits, 10/11 two stop bits
- BC  in  1  break control: forces SOUT=0
- TX_DATA  in  DW  word to send
- TX_VALID  in  1  TX_DATA is valid
- TX_READY  out  1  holding register is empty
- BUSY  out  1  a frame is in progress (FSM not IDLE)
- TXFINISHED  out  1  one-CLK pulse at the end of each frame
- SOUT  out  1  serial output, registered

Behaviour:
- Reset values: SOUT=1, TX_READY=1, BUSY=0, TXFINISHED=0; FSM=IDLE; holding register empty; all counters 0.
- Handshake:
  - A word is accepted on a CLK edge with TX_VALID & TX_READY; TX_DATA is latched into the holding register.
  - TX_READY falls on the next cycle and stays low until the word moves to the shift register.
- Load:
  - Happens on the CLK edge where the holding register is full and either (FSM=IDLE) or (last stop tick is being consumed).
  - WLEN, PMODE and STOPB are captured into the frame config at load. Changes mid-frame have no effect until the next load.
  - The holding register frees on the load edge, so TX_READY=1 on the following cycle. A new word may be accepted in that same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on load.
  - START -> DATA.
  - DATA repeats until the bit counter equals captured WLEN-1. It then goes to PARITY if PMODE != none, else to STOP.
  - PARITY -> STOP.
  - STOP -> START if the holding register is full at the final stop tick, else -> IDLE.
- Timing:
  - The tick counter advances only on TXCLK=1.
  - Each state lasts exactly OVERSAMPLE ticks.
  - STOP lasts OVERSAMPLE, 3*OVERSAMPLE/2 or 2*OVERSAMPLE ticks for STOPB 00, 01, 1x respectively.
  - The tick counter resets at every state change.
- SOUT is registered from the FSM state and shift data:
  - START=0; DATA=current LSB of the shift register; STOP/IDLE=1.
  - PARITY=XOR of the WLEN data bits (even mode), its inverse (odd mode), 1 (mark), 0 (space).
  - SOUT changes one CLK after the state transition. A load in IDLE therefore produces SOUT=0 on the cycle after the load edge.
- TXFINISHED pulses high for exactly one CLK on the edge leaving STOP, including the STOP->START case.
- BC=1 forces SOUT=0 combinationally after the output register. FSM, counters and handshake continue unaffected.
- CLEAR=1 (synchronous, priority over load and accept):
  - FSM -> IDLE, holding register emptied, counters zeroed, SOUT=1.
  - No TXFINISHED pulse.
  - TX_READY=1 the next cycle.
- RST asserted mid-frame gives the reset values immediately; the frame is truncated.
- BUSY=1 whenever FSM != IDLE.

Optional Feature:
- Macro: UART_TX_CTS_FLOW_EN.
- When defined:
  - Adds input CTS_N (1 bit, active-low, already synchronised).
  - A load is suppressed while CTS_N=1; a word stays in the holding register and TX_READY stays 0.
  - A frame already in progress always completes.
  - Deasserting CTS_N during STOP forces STOP->IDLE even if the holding register is full.
- When undefined: no CTS_N port; loads depend only on holding-register state.

Test Plan:
1. Frame 8N1: OVERSAMPLE=4, TXCLK=1 every cycle, WLEN=8, PMODE=000, STOPB=00, send 0xA5.
   -> SOUT = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); TXFINISHED single pulse at the end; BUSY=0 afterwards.
2. Parity: WLEN=7, data 0x41.
   -> Even-mode parity bit=0; odd=1; mark=1; space=0.
   -> Frame with WLEN=5, data 0x1F: even parity bit=1.
3. Stop bits and back-to-back:
   - STOPB=01: stop lasts 6 cycles.
   - STOPB=10: stop lasts 8 cycles.
   - Two words offered back-to-back (0x55, 0xAA): second START begins the cycle after the last stop cycle, no gap; TX_READY re-asserts after each load; two TXFINISHED pulses.
4. Word-length clamp: WLEN=4'hF with DW=8.
   -> 8 data bits sent.
   -> Changing WLEN to 5 mid-frame does not shorten the current frame; the next frame uses 5 bits.
5. CLEAR and reset:
   - CLEAR pulsed during data bit 3 -> SOUT=1 next cycle, BUSY=0, no TXFINISHED, TX_READY=1.
   - RST asserted mid-frame -> same output state asynchronously.
6. Break and CTS:
   - BC=1 during a frame -> SOUT=0 throughout while TXFINISHED still pulses at the normal time.
   - With UART_TX_CTS_FLOW_EN and CTS_N=1: word is accepted, then SOUT stays 1 and TX_READY stays 0. CTS_N->0 starts the frame on the next cycle.

Source files
------------

// File: rtl/uart_tx_frame_engine.sv
// UART transmit frame engine: ready/valid word in, start/data/parity/stop frame out on SOUT.
// Optional CTS flow control is enabled with `define UART_TX_CTS_FLOW_EN (adds input CTS_N).
module uart_tx_frame_engine #(
    parameter int unsigned DW         = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          TXCLK,
    input  logic          CLEAR,
    input  logic [3:0]    WLEN,
    input  logic [2:0]    PMODE,
    input  logic [1:0]    STOPB,
    input  logic          BC,
    input  logic [DW-1:0] TX_DATA,
    input  logic          TX_VALID,
`ifdef UART_TX_CTS_FLOW_EN
    input  logic          CTS_N,
`endif
    output logic          TX_READY,
    output logic          BUSY,
    output logic          TXFINISHED,
    output logic          SOUT
);

    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
    localparam int unsigned BW = 4;
    localparam logic [BW-1:0] DW_L   = BW'(DW);
    localparam logic [TW-1:0] T_ONE  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_ONEH = TW'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [TW-1:0] T_TWO  = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [DW-1:0] shift, shift_n;
    logic [DW-1:0] hold, hold_n;
    logic          hold_full, hold_full_n;
    logic [BW-1:0] cfg_wlen, cfg_wlen_n;
    logic          cfg_par_en, cfg_par_en_n;
    logic          cfg_par_bit, cfg_par_bit_n;
    logic [1:0]    cfg_stopb, cfg_stopb_n;
    logic          sout_q, sout_n;
    logic          ready_q, busy_q, fin_q, fin_n;

    logic [BW-1:0] wlen_eff;
    logic [DW-1:0] mask;
    logic          data_xor;
    logic [TW-1:0] dur_m1;
    logic          last_tick;
    logic          cts_ok;
    logic          load;
    logic          accept;

`ifdef UART_TX_CTS_FLOW_EN
    assign cts_ok = ~CTS_N;
`else
    assign cts_ok = 1'b1;
`endif

    // Next-state, frame config capture and output decode
    always_comb begin
        state_n       = state;
        tick_n        = tick;
        bit_n         = bit_cnt;
        shift_n       = shift;
        hold_n        = hold;
        hold_full_n   = hold_full;
        cfg_wlen_n    = cfg_wlen;
        cfg_par_en_n  = cfg_par_en;
        cfg_par_bit_n = cfg_par_bit;
        cfg_stopb_n   = cfg_stopb;
        fin_n         = 1'b0;
        sout_n        = 1'b1;
        mask          = '0;

        wlen_eff = (WLEN < 4'd5 || WLEN > DW_L) ? DW_L : WLEN;
        for (int i = 0; i < int'(DW); i++) begin
            mask[i] = (BW'(i) < wlen_eff);
        end
        data_xor = ^(hold & mask);

        if (state == ST_STOP) begin
            case (cfg_stopb)
                2'b00:   dur_m1 = T_ONE;
                2'b01:   dur_m1 = T_ONEH;
                default: dur_m1 = T_TWO;
            endcase
        end else begin
            dur_m1 = T_ONE;
        end
        last_tick = TXCLK && (state != ST_IDLE) && (tick == dur_m1);
        load      = hold_full && cts_ok &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && last_tick));
        accept    = TX_VALID && ready_q;

        if (TXCLK && state != ST_IDLE) begin
            tick_n = tick + TW'(1);
        end

        if (last_tick) begin
            tick_n = '0;
            case (state)
                ST_START: begin
                    state_n = ST_DATA;
                    bit_n   = '0;
                end
                ST_DATA: begin
                    if (bit_cnt == cfg_wlen - BW'(1)) begin
                        state_n = cfg_par_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_n   = bit_cnt + BW'(1);
                        shift_n = shift >> 1;
                    end
                end
                ST_PARITY: state_n = ST_STOP;
                ST_STOP: begin
                    state_n = ST_IDLE;
                    fin_n   = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (accept) begin
            hold_n      = TX_DATA;
            hold_full_n = 1'b1;
        end

        if (load) begin
            state_n      = ST_START;
            tick_n       = '0;
            bit_n        = '0;
            shift_n      = hold;
            hold_full_n  = 1'b0;
            cfg_wlen_n   = wlen_eff;
            cfg_stopb_n  = STOPB;
            cfg_par_en_n = (PMODE >= 3'd1) && (PMODE <= 3'd4);
            case (PMODE)
                3'd1:    cfg_par_bit_n = ~data_xor;
                3'd2:    cfg_par_bit_n = data_xor;
                3'd3:    cfg_par_bit_n = 1'b1;
                default: cfg_par_bit_n = 1'b0;
            endcase
        end

        if (CLEAR) begin
            state_n     = ST_IDLE;
            tick_n      = '0;
            bit_n       = '0;
            hold_full_n = 1'b0;
            fin_n       = 1'b0;
        end

        case (state_n)
            ST_START:  sout_n = 1'b0;
            ST_DATA:   sout_n = shift_n[0];
            ST_PARITY: sout_n = cfg_par_bit_n;
            default:   sout_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            tick        <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            cfg_wlen    <= '0;
            cfg_par_en  <= 1'b0;
            cfg_par_bit <= 1'b0;
            cfg_stopb   <= '0;
            sout_q      <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state       <= state_n;
            tick        <= tick_n;
            bit_cnt     <= bit_n;
            shift       <= shift_n;
            hold        <= hold_n;
            hold_full   <= hold_full_n;
            cfg_wlen    <= cfg_wlen_n;
            cfg_par_en  <= cfg_par_en_n;
            cfg_par_bit <= cfg_par_bit_n;
            cfg_stopb   <= cfg_stopb_n;
            sout_q      <= sout_n;
            ready_q     <= ~hold_full_n;
            busy_q      <= (state_n != ST_IDLE);
            fin_q       <= fin_n;
        end
    end

    // Break forces the line low after the output register
    assign SOUT       = sout_q & ~BC;
    assign TX_READY   = ready_q;
    assign BUSY       = busy_q;
    assign TXFINISHED = fin_q;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Self-checking bench for uart_tx_frame_engine: per-cycle line model built from frame rules.
module tb_uart_tx_frame_engine;

    localparam int OS = 4;

    logic       CLK = 1'b0;
    logic       RST, TXCLK, CLEAR, BC, TX_VALID;
    logic [3:0] WLEN;
    logic [2:0] PMODE;
    logic [1:0] STOPB;
    logic [7:0] TX_DATA;
    logic       TX_READY, BUSY, TXFINISHED, SOUT;
`ifdef UART_TX_CTS_FLOW_EN
    logic       CTS_N;
`endif

    uart_tx_frame_engine #(.DW(8), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RST(RST), .TXCLK(TXCLK), .CLEAR(CLEAR),
        .WLEN(WLEN), .PMODE(PMODE), .STOPB(STOPB), .BC(BC),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
`ifdef UART_TX_CTS_FLOW_EN
        .CTS_N(CTS_N),
`endif
        .TX_READY(TX_READY), .BUSY(BUSY), .TXFINISHED(TXFINISHED), .SOUT(SOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic sout;
        logic busy;
        logic fin;
    } ent_t;

    ent_t exp_q[$];
    logic pend_fin = 1'b0;
    logic bc_m = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic s, input logic b);
        ent_t e;
        e.sout = s & ~bc_m;
        e.busy = b;
        e.fin  = pend_fin;
        pend_fin = 1'b0;
        exp_q.push_back(e);
    endtask

    // Expected line, one entry per CLK with TXCLK always high
    task automatic add_frame(input logic [7:0] d, input logic [3:0] wl,
                             input logic [2:0] pm, input logic [1:0] sb);
        int   n;
        int   stop_t;
        logic p;
        n = (wl < 4'd5 || wl > 4'd8) ? 8 : int'(wl);
        p = 1'b0;
        repeat (OS) push(1'b0, 1'b1);
        for (int i = 0; i < n; i++) begin
            p = p ^ d[i];
            repeat (OS) push(d[i], 1'b1);
        end
        if (pm == 3'd1) repeat (OS) push(~p, 1'b1);
        if (pm == 3'd2) repeat (OS) push(p, 1'b1);
        if (pm == 3'd3) repeat (OS) push(1'b1, 1'b1);
        if (pm == 3'd4) repeat (OS) push(1'b0, 1'b1);
        stop_t = (sb == 2'd0) ? OS : (sb == 2'd1) ? (3 * OS) / 2 : 2 * OS;
        repeat (stop_t) push(1'b1, 1'b1);
        pend_fin = 1'b1;
    endtask

    task automatic play(input int n);
        ent_t e;
        logic acc;
        for (int i = 0; i < n; i++) begin
            acc = TX_VALID && TX_READY;
            @(posedge CLK);
            #1;
            if (acc) TX_VALID = 1'b0;
            if (exp_q.size() == 0) push(1'b1, 1'b0);
            e = exp_q.pop_front();
            chk("sout", 32'(SOUT), 32'(e.sout));
            chk("busy", 32'(BUSY), 32'(e.busy));
            chk("txfinished", 32'(TXFINISHED), 32'(e.fin));
        end
    endtask

    task automatic setup(input logic [7:0] d, input logic [3:0] wl,
                         input logic [2:0] pm, input logic [1:0] sb);
        TX_DATA = d; WLEN = wl; PMODE = pm; STOPB = sb; TX_VALID = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] wl,
                        input logic [2:0] pm, input logic [1:0] sb);
        setup(d, wl, pm, sb);
        chk("ready_idle", 32'(TX_READY), 32'd1);
        push(1'b1, 1'b0);
        add_frame(d, wl, pm, sb);
        push(1'b1, 1'b0);
        play(1);
        chk("ready_after_accept", 32'(TX_READY), 32'd0);
        play(1);
        chk("ready_after_load", 32'(TX_READY), 32'd1);
        play(exp_q.size());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l1;
        RST = 1'b1; TXCLK = 1'b1; CLEAR = 1'b0; BC = 1'b0; TX_VALID = 1'b0;
        WLEN = 4'd8; PMODE = 3'd0; STOPB = 2'd0; TX_DATA = 8'h00;
`ifdef UART_TX_CTS_FLOW_EN
        CTS_N = 1'b0;
`endif
        #1;
        chk("reset_sout", 32'(SOUT), 32'd1);
        chk("reset_ready", 32'(TX_READY), 32'd1);
        chk("reset_busy", 32'(BUSY), 32'd0);
        chk("reset_fin", 32'(TXFINISHED), 32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        play(2);

        // 8N1 reference frame
        send(8'hA5, 4'd8, 3'd0, 2'd0);

        // Parity modes
        send(8'h41, 4'd7, 3'd2, 2'd0);
        send(8'h41, 4'd7, 3'd1, 2'd0);
        send(8'h41, 4'd7, 3'd3, 2'd0);
        send(8'h41, 4'd7, 3'd4, 2'd0);
        send(8'h1F, 4'd5, 3'd2, 2'd0);
        send(8'h1F, 4'd5, 3'd6, 2'd0);

        // Stop lengths
        send(8'h33, 4'd8, 3'd0, 2'd1);
        send(8'h33, 4'd8, 3'd0, 2'd2);
        send(8'h33, 4'd8, 3'd0, 2'd3);

        // Back-to-back words, no idle gap
        setup(8'h55, 4'd8, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        add_frame(8'h55, 4'd8, 3'd0, 2'd0);
        l1 = exp_q.size() - 1;
        play(2);
        chk("b2b_ready_load1", 32'(TX_READY), 32'd1);
        setup(8'hAA, 4'd8, 3'd0, 2'd0);
        add_frame(8'hAA, 4'd8, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        play(1);
        chk("b2b_ready_full", 32'(TX_READY), 32'd0);
        play(l1 - 1);
        chk("b2b_ready_load2", 32'(TX_READY), 32'd1);
        play(exp_q.size());

        // Word-length clamp and mid-frame WLEN change
        setup(8'hC3, 4'hF, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        add_frame(8'hC3, 4'hF, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        play(10);
        WLEN = 4'd5;
        play(exp_q.size());
        send(8'hC3, 4'd5, 3'd0, 2'd0);

        // CLEAR during data bit 3 with a second word held
        setup(8'h00, 4'd8, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        add_frame(8'h00, 4'd8, 3'd0, 2'd0);
        play(2);
        setup(8'h3C, 4'd8, 3'd0, 2'd0);
        play(4 * OS + 1);
        CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        exp_q.delete();
        pend_fin = 1'b0;
        chk("clear_sout", 32'(SOUT), 32'd1);
        chk("clear_busy", 32'(BUSY), 32'd0);
        chk("clear_fin", 32'(TXFINISHED), 32'd0);
        chk("clear_ready", 32'(TX_READY), 32'd1);
        play(6);

        // Asynchronous reset mid-frame
        setup(8'h00, 4'd8, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        add_frame(8'h00, 4'd8, 3'd0, 2'd0);
        play(10);
        RST = 1'b1;
        #1;
        chk("rst_sout", 32'(SOUT), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_fin", 32'(TXFINISHED), 32'd0);
        chk("rst_ready", 32'(TX_READY), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_q.delete();
        pend_fin = 1'b0;
        play(4);

        // Break holds the line low; frame timing continues
        BC = 1'b1; bc_m = 1'b1;
        send(8'h5A, 4'd8, 3'd2, 2'd0);
        BC = 1'b0; bc_m = 1'b0;
        play(2);

`ifdef UART_TX_CTS_FLOW_EN
        // CTS_N high blocks the load until it is released
        CTS_N = 1'b1;
        setup(8'h96, 4'd8, 3'd0, 2'd0);
        repeat (6) push(1'b1, 1'b0);
        play(6);
        chk("cts_ready_held", 32'(TX_READY), 32'd0);
        CTS_N = 1'b0;
        add_frame(8'h96, 4'd8, 3'd0, 2'd0);
        push(1'b1, 1'b0);
        play(exp_q.size());
`endif

        // Randomised frames
        for (int k = 0; k < 24; k++) begin
            send(8'($urandom), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            play($urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
